// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding select and interlock unit for the in-order pipeline
//
// Tracks the destination register of every instruction in flight over DEPTH
// stages after ID (stage 0 = EX, stage DEPTH-1 = WB). Each record carries the
// first stage at which its result is visible in a pipeline latch, which lets
// multi-cycle producers such as loads stall their consumers.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   issue_valid       valid instruction in ID
//   issue_rd          its destination register
//   issue_we          it writes the register file
//   issue_avail       first stage index whose latch holds its result
//   rs_addr           NPORTS source addresses, port p at [p*RW +: RW]
//   rs_used           per-port read enable
//   hold              downstream freeze, latches do not advance
//   flush             squash the ID instruction
//   fwd_sel           per port: 0 = register file, k = stage k-1 latch
//   stall             ID must hold this cycle
//   stall_count       cycles stalled (hold=0), wrapping
module hazard_scoreboard #(
    parameter int RW     = 5,
    parameter int NPORTS = 2,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH + 1),
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [RW-1:0]           issue_rd,
    input  logic                    issue_we,
    input  logic [SEL_W-1:0]        issue_avail,
    input  logic [NPORTS*RW-1:0]    rs_addr,
    input  logic [NPORTS-1:0]       rs_used,
    input  logic                    hold,
    input  logic                    flush,
    output logic [NPORTS*SEL_W-1:0] fwd_sel,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_count
);

    logic             pipe_valid [DEPTH];
    logic [RW-1:0]    pipe_rd    [DEPTH];
    logic [SEL_W-1:0] pipe_avail [DEPTH];

    logic [NPORTS-1:0] stall_req;
    logic              push;
    logic [SEL_W-1:0]  avail_clamped;

    // Walk from oldest to youngest so the last match written is the youngest
    // producer; that record alone decides forward vs. stall for the port.
    always_comb begin
        fwd_sel   = '0;
        stall_req = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (rs_used[p] && (rs_addr[p*RW +: RW] != '0)) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (pipe_valid[k] && (pipe_rd[k] == rs_addr[p*RW +: RW])) begin
                        if (SEL_W'(k) >= pipe_avail[k]) begin
                            fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
                            stall_req[p]              = 1'b0;
                        end else begin
                            fwd_sel[p*SEL_W +: SEL_W] = '0;
                            stall_req[p]              = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A flushed ID instruction dies, so it neither stalls nor records.
    assign stall = issue_valid & ~flush & (|stall_req);
    assign push  = issue_valid & ~stall & ~flush & issue_we & (issue_rd != '0);

    // A producer claiming availability beyond WB is treated as available at WB.
    assign avail_clamped = (issue_avail >= SEL_W'(DEPTH)) ? SEL_W'(DEPTH - 1) : issue_avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_valid[k] <= 1'b0;
                pipe_rd[k]    <= '0;
                pipe_avail[k] <= '0;
            end
            stall_count <= '0;
        end else if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_rd[k]    <= pipe_rd[k-1];
                pipe_avail[k] <= pipe_avail[k-1];
            end
            // A stall inserts a bubble here, letting the producer move on.
            pipe_valid[0] <= push;
            pipe_rd[0]    <= push ? issue_rd : '0;
            pipe_avail[0] <= push ? avail_clamped : '0;
            if (stall) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    localparam int RW = 5, NPORTS = 2, DEPTH = 3, SEL_W = 2, CNT_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    issue_valid;
    logic [RW-1:0]           issue_rd;
    logic                    issue_we;
    logic [SEL_W-1:0]        issue_avail;
    logic [NPORTS*RW-1:0]    rs_addr;
    logic [NPORTS-1:0]       rs_used;
    logic                    hold;
    logic                    flush;
    logic [NPORTS*SEL_W-1:0] fwd_sel;
    logic                    stall;
    logic [CNT_W-1:0]        stall_count;

    hazard_scoreboard #(.RW(RW), .NPORTS(NPORTS), .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_we(issue_we), .issue_avail(issue_avail), .rs_addr(rs_addr),
        .rs_used(rs_used), .hold(hold), .flush(flush), .fwd_sel(fwd_sel),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit       v;
        int       rd;
        bit       we;
        int       av;
        int       rs0;
        int       rs1;
        bit [1:0] used;
        bit       hold;
        bit       flush;
        bit       rst;
        int       e_sel0;
        int       e_sel1;
        bit       e_stall;
        int       e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input bit v, input int rd, input bit we, input int av,
                         input int rs0, input int rs1, input bit [1:0] used,
                         input bit h, input bit f, input bit r);
        issue_valid = v;
        issue_rd    = RW'(rd);
        issue_we    = we;
        issue_avail = SEL_W'(av);
        rs_addr     = {RW'(rs1), RW'(rs0)};
        rs_used     = used;
        hold        = h;
        flush       = f;
        rst         = r;
    endtask

    // Reference model: list of in-flight records, index = stage (0 youngest).
    typedef struct {
        bit v;
        int rd;
        int av;
    } rec_t;

    rec_t mq[$];
    int   mcount;

    task automatic model_reset();
        rec_t b;
        b = '{v: 0, rd: 0, av: 0};
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back(b);
        mcount = 0;
    endtask

    task automatic model_eval(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                              input bit f, output int sel0, output int sel1, output bit st);
        int  addr;
        int  sel[2];
        bit  req;
        req = 0;
        for (int p = 0; p < 2; p++) begin
            addr   = (p == 0) ? rs0 : rs1;
            sel[p] = 0;
            if (used[p] && addr != 0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (mq[k].v && mq[k].rd == addr) begin
                        if (k >= mq[k].av) sel[p] = k + 1;
                        else req = 1;
                        break;
                    end
                end
            end
        end
        sel0 = sel[0];
        sel1 = sel[1];
        st   = v && !f && req;
    endtask

    task automatic model_step(input bit v, input int rd, input bit we, input int av,
                              input bit h, input bit f, input bit r, input bit st);
        rec_t n;
        if (r) begin
            model_reset();
        end else if (!h) begin
            if (st) mcount++;
            n.v  = v && !st && !f && we && rd != 0;
            n.rd = n.v ? rd : 0;
            n.av = n.v ? ((av >= DEPTH) ? DEPTH - 1 : av) : 0;
            void'(mq.pop_back());
            mq.push_front(n);
        end
    endtask

    initial begin
        int  s0, s1;
        bit  st;
        bit  v, we, h, f, r;
        int  rd, av, a0, a1;
        bit [1:0] used;

        // v  rd we av rs0 rs1 used hold flush rst | sel0 sel1 stall cnt
        vecs.push_back('{1, 5,1,0, 0, 0,2'b00,0,0,0, 0,0,0,0}); // ALU producer rd=5
        vecs.push_back('{1, 0,0,0, 5, 0,2'b01,0,0,0, 1,0,0,0});
        vecs.push_back('{1, 0,0,0, 5, 0,2'b01,0,0,0, 2,0,0,0});
        vecs.push_back('{1, 0,0,0, 5, 0,2'b01,0,0,0, 3,0,0,0});
        vecs.push_back('{1, 0,0,0, 5, 0,2'b01,0,0,0, 0,0,0,0});
        vecs.push_back('{1, 7,1,1, 0, 0,2'b00,0,0,0, 0,0,0,0}); // load rd=7
        vecs.push_back('{1, 0,0,0, 0, 7,2'b10,0,0,0, 0,0,1,0}); // load-use stall
        vecs.push_back('{1, 0,0,0, 0, 7,2'b10,0,0,0, 0,2,0,1});
        vecs.push_back('{1, 3,1,0, 0, 0,2'b00,0,0,0, 0,0,0,1}); // rd=3 twice
        vecs.push_back('{1, 3,1,0, 0, 0,2'b00,0,0,0, 0,0,0,1});
        vecs.push_back('{1, 0,0,0, 3, 3,2'b11,0,0,0, 1,1,0,1}); // youngest wins
        vecs.push_back('{1, 0,1,0, 0, 0,2'b00,0,0,0, 0,0,0,1}); // write to x0
        vecs.push_back('{1, 0,0,0, 0, 0,2'b11,0,0,0, 0,0,0,1});
        vecs.push_back('{1, 9,1,1, 0, 0,2'b00,0,0,0, 0,0,0,1}); // load rd=9
        vecs.push_back('{1, 0,0,0, 1, 9,2'b01,0,0,0, 0,0,0,1}); // jump: port1 masked
        vecs.push_back('{1, 4,1,1, 0, 0,2'b00,0,0,0, 0,0,0,1}); // load rd=4
        vecs.push_back('{1, 0,0,0, 4, 0,2'b01,1,0,0, 0,0,1,1}); // hold x3
        vecs.push_back('{1, 0,0,0, 4, 0,2'b01,1,0,0, 0,0,1,1});
        vecs.push_back('{1, 0,0,0, 4, 0,2'b01,1,0,0, 0,0,1,1});
        vecs.push_back('{1, 6,1,0, 4, 0,2'b01,0,1,0, 0,0,0,1}); // flush with rd=6
        vecs.push_back('{1, 0,0,0, 6, 4,2'b11,0,0,0, 0,2,0,1});
        vecs.push_back('{1,10,1,0, 0, 0,2'b00,0,0,0, 0,0,0,1});
        vecs.push_back('{1,11,1,0, 0, 0,2'b00,0,0,0, 0,0,0,1});
        vecs.push_back('{1,12,1,2, 0, 0,2'b00,0,0,0, 0,0,0,1});
        vecs.push_back('{1, 0,0,0,12,10,2'b11,0,0,1, 0,3,1,1}); // rst with stall pending
        vecs.push_back('{1, 0,0,0,12,10,2'b11,0,0,0, 0,0,0,0});

        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 5, 7, 2'b11, 0, 0, 0);
        #1;
        chk("reset_fwd_sel", 32'(fwd_sel), 0);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_count", stall_count, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].rd, vecs[i].we, vecs[i].av, vecs[i].rs0, vecs[i].rs1,
                  vecs[i].used, vecs[i].hold, vecs[i].flush, vecs[i].rst);
            #1;
            chk($sformatf("vec%0d_sel0", i), 32'(fwd_sel[1:0]), 32'(vecs[i].e_sel0));
            chk($sformatf("vec%0d_sel1", i), 32'(fwd_sel[3:2]), 32'(vecs[i].e_sel1));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_count", i), stall_count, 32'(vecs[i].e_cnt));
            @(negedge clk);
        end

        // Randomized phase against the reference model, starting from reset.
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        @(negedge clk);
        model_reset();
        for (int c = 0; c < 600; c++) begin
            v    = ($urandom_range(0, 9) < 8);
            rd   = $urandom_range(0, 7);
            we   = ($urandom_range(0, 3) != 0);
            av   = $urandom_range(0, 3);
            a0   = $urandom_range(0, 7);
            a1   = $urandom_range(0, 7);
            used = 2'($urandom_range(0, 3));
            h    = ($urandom_range(0, 9) == 0);
            f    = ($urandom_range(0, 9) == 0);
            r    = ($urandom_range(0, 63) == 0);
            drive(v, rd, we, av, a0, a1, used, h, f, r);
            #1;
            model_eval(v, a0, a1, used, f, s0, s1, st);
            chk($sformatf("rnd%0d_sel0", c), 32'(fwd_sel[1:0]), 32'(s0));
            chk($sformatf("rnd%0d_sel1", c), 32'(fwd_sel[3:2]), 32'(s1));
            chk($sformatf("rnd%0d_stall", c), 32'(stall), 32'(st));
            chk($sformatf("rnd%0d_count", c), stall_count, 32'(mcount));
            model_step(v, rd, we, av, h, f, r, st);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised forwarding and interlock unit for the in-order pipeline, successor to the combinational two-stage forward selector. Tracks destination-register records of instructions in flight over DEPTH stages after ID (stage 0 = EX, stage DEPTH-1 = WB). Per-record "available-from" stage lets it handle multi-cycle producers (loads, multiply). Produces a per-read-port forward select, a load-use/latency stall, and a stall-cycle counter. Supports NPORTS read ports.

Parameters:
- RW, 5, register-address width; address 0 is hardwired zero and never forwarded or stalled on.
- NPORTS, 2, number of ID read ports checked.
- DEPTH, 3, tracked stages after ID (EX, MEM, WB).
- SEL_W, $clog2(DEPTH+1), width of each forward select and of issue_avail.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  valid instruction in ID
- issue_rd  in  RW  its destination register
- issue_we  in  1  it writes the register file
- issue_avail  in  SEL_W  first stage index whose pipeline latch holds its result (0 = ALU, 1 = load at MEM)
- rs_addr  in  NPORTS*RW  source addresses; port p occupies bits [p*RW +: RW]
- rs_used  in  NPORTS  port p is actually read (jump: rs1 only; branch/ALU: both)
- hold  in  1  downstream freeze; pipeline latches do not advance
- flush  in  1  squash the ID instruction (taken branch or jump)
- fwd_sel  out  NPORTS*SEL_W  per port: 0 = register file; k = forward from the stage k-1 latch
- stall  out  1  ID must hold this cycle
- stall_count  out  CNT_W  count of cycles stalled

Behaviour:
- State: DEPTH entries pipe[k] = {valid, rd, avail}. Only entries with we=1 and rd!=0 are stored valid.
- Reset: all entries invalid; stall_count = 0. Resulting outputs: fwd_sel = 0, stall = 0. Reset mid-operation drops all records in one cycle.
- Advance (posedge, rst=0, hold=0):
  - pipe[k] <= pipe[k-1] for k >= 1.
  - pipe[0] <= record when push, else an invalid bubble.
  - push = issue_valid & ~stall & ~flush & issue_we & (issue_rd != 0).
  - issue_avail >= DEPTH is clamped to DEPTH-1 at push.
- hold=1: all entries and stall_count are unchanged; no push, even if flush is asserted.
- Entry leaving pipe[DEPTH-1] is discarded. The register file must already hold that value (write-then-read).
- Combinational per port p, when rs_used[p]=1 and rs_addr[p]!=0:
  - Find the lowest k with pipe[k].valid and pipe[k].rd == rs_addr[p] (youngest producer wins).
  - If found and k >= pipe[k].avail: fwd_sel[p] = k+1.
  - If found and k < avail: fwd_sel[p] = 0, and port p requests a stall.
  - If not found: fwd_sel[p] = 0.
- Ports with rs_used=0 or address 0 give fwd_sel = 0 and no stall request.
- stall = issue_valid & ~flush & OR(port stall requests). flush suppresses the stall, because the ID instruction dies.
- A stall cycle (hold=0) shifts a bubble into pipe[0]. The producer therefore advances, and the stall releases automatically once the producer reaches its avail stage.
- stall_count increments when stall=1 and hold=0, and wraps modulo 2^CNT_W.
- No latency on outputs; the only registered state is pipe[] and stall_count.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: issue rd=5, avail=0. Next cycle, ID reads rs_addr port0=5.
  - Response: fwd_sel[0]=1, stall=0. One cycle later (no new writer): fwd_sel[0]=2. Then fwd_sel[0]=3. Then 0.
- Load-use:
  - Stimulus: issue rd=7, avail=1. Next cycle, port1 reads 7.
  - Response: stall=1 for exactly 1 cycle with fwd_sel[1]=0. Then fwd_sel[1]=2 and stall=0. stall_count = 1.
- Youngest priority and x0:
  - Stimulus: rd=3 issued twice consecutively (avail=0), then read 3 on both ports.
  - Response: both fwd_sel=1. Separately, rd=0 with we=1, then read 0 -> fwd_sel=0, stall=0.
- rs_used masking:
  - Stimulus: load to rd=9, then a jump with rs_addr port0=1, port1=9, rs_used=2'b01.
  - Response: stall=0, fwd_sel=0 on both ports.
- hold and flush:
  - Stimulus: load rd=4 in pipe[0]; dependent reader in ID; hold=1 for 3 cycles.
  - Response: stall=1 stays asserted, pipe is frozen, stall_count is unchanged.
  - Continuation: hold drops; flush=1 together with a valid issue of rd=6.
  - Response: stall=0, no push, and later reads of 6 give fwd_sel=0.
- Reset mid-flight:
  - Stimulus: three valid entries plus a pending stall; assert rst for 1 cycle.
  - Response: next cycle all fwd_sel=0, stall=0, stall_count=0.
